// File: rtl/mux_gate_if.sv
// Signal bundle for the gate-level N:1 mux cell.
// MUX_GATE_EDGE_EN adds the registered change pulse edge_p.
interface mux_gate_if #(
    parameter int SEL_W = 2
);
    localparam int N = 2 ** SEL_W;

    logic [N-1:0]     in;
    logic [SEL_W-1:0] sel;
    logic             out;
    logic [N-1:0]     sel_dec;
    logic             out_q;
`ifdef MUX_GATE_EDGE_EN
    logic             edge_p;
`endif

`ifdef MUX_GATE_EDGE_EN
    modport master (output in, sel, input out, sel_dec, out_q, edge_p);
    modport slave  (input in, sel, output out, sel_dec, out_q, edge_p);
`else
    modport master (output in, sel, input out, sel_dec, out_q);
    modport slave  (input in, sel, output out, sel_dec, out_q);
`endif

endinterface

// File: rtl/mux_gate.sv
// Gate-level N:1 one-bit mux with one-hot select decode and a registered output copy.
// Optional macro MUX_GATE_EDGE_EN adds edge_p, a one-cycle pulse whenever out_q changes.
module mux_gate #(
    parameter int SEL_W = 2
) (
    input  logic         clk,
    input  logic         rst,
    mux_gate_if.slave    bus
);
    localparam int N = 2 ** SEL_W;

    wire [SEL_W-1:0] sel_n;
    wire [N-1:0]     dec;
    wire [N-1:0]     term;
    wire [N-1:0]     or_chain;

    logic out_q;

    for (genvar j = 0; j < SEL_W; j++) begin : g_inv
        not u_not (sel_n[j], bus.sel[j]);
    end

    // Each decode line ANDs one literal per select bit: true or complemented per bit j of i.
    for (genvar i = 0; i < N; i++) begin : g_dec
        wire [SEL_W-1:0] lit;
        wire [SEL_W-1:0] and_chain;

        for (genvar j = 0; j < SEL_W; j++) begin : g_lit
            if (((i >> j) & 1) == 1) begin : g_pos
                assign lit[j] = bus.sel[j];
            end else begin : g_neg
                assign lit[j] = sel_n[j];
            end
        end

        assign and_chain[0] = lit[0];
        for (genvar j = 1; j < SEL_W; j++) begin : g_and
            and u_and (and_chain[j], and_chain[j-1], lit[j]);
        end

        assign dec[i] = and_chain[SEL_W-1];
        and u_term (term[i], bus.in[i], dec[i]);
    end

    // Only the selected term can be high, so a plain OR chain forms the output.
    assign or_chain[0] = term[0];
    for (genvar i = 1; i < N; i++) begin : g_or
        or u_or (or_chain[i], or_chain[i-1], term[i]);
    end

    assign bus.sel_dec = dec;
    assign bus.out     = or_chain[N-1];

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= 1'b0;
        end else begin
            out_q <= bus.out;
        end
    end

    assign bus.out_q = out_q;

`ifdef MUX_GATE_EDGE_EN
    logic edge_p;

    // Compares the value about to be loaded with the value being replaced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_p <= 1'b0;
        end else begin
            edge_p <= bus.out ^ out_q;
        end
    end

    assign bus.edge_p = edge_p;
`endif

    a_dec_onehot : assert property (@(posedge clk) !$isunknown(bus.sel) |-> $onehot(dec));

endmodule

// File: tb/tb_mux_gate.sv
// Scoreboard bench for mux_gate: a driver pushes model expectations, two monitors pop and compare.
// Build with or without MUX_GATE_EDGE_EN; edge_p is checked only when the macro is defined.
module tb_mux_gate;
    localparam int SEL_W = 2;
    localparam int N     = 2 ** SEL_W;

    logic clk = 1'b0;
    logic rst;

    mux_gate_if #(.SEL_W(SEL_W)) bus ();

    mux_gate #(.SEL_W(SEL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         out;
        logic [N-1:0] dec;
    } comb_exp_t;

    typedef struct {
        logic q;
        logic e;
    } reg_exp_t;

    comb_exp_t comb_q[$];
    reg_exp_t  reg_q[$];

    int   n_checks = 0;
    int   n_pass   = 0;
    logic model_q  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One stimulus cycle; the reference model is plain indexing plus a remembered last capture.
    task automatic step(input logic [N-1:0] in_v, input logic [SEL_W-1:0] sel_v, input logic rst_v);
        comb_exp_t c;
        reg_exp_t  r;
        @(posedge clk);
        #2;
        rst     = rst_v;
        bus.in  = in_v;
        bus.sel = sel_v;
        c.out          = in_v[sel_v];
        c.dec          = '0;
        c.dec[sel_v]   = 1'b1;
        comb_q.push_back(c);
        if (rst_v) begin
            r.q = 1'b0;
            r.e = 1'b0;
        end else begin
            r.q = c.out;
            r.e = (c.out != model_q);
        end
        model_q = r.q;
        reg_q.push_back(r);
    endtask

    initial begin
        comb_exp_t c;
        forever begin
            @(negedge clk);
            if (comb_q.size() > 0) begin
                c = comb_q.pop_front();
                check("out", 32'(bus.out), 32'(c.out));
                check("sel_dec", 32'(bus.sel_dec), 32'(c.dec));
            end
        end
    end

    initial begin
        reg_exp_t r;
        forever begin
            @(posedge clk);
            #1;
            if (reg_q.size() > 0) begin
                r = reg_q.pop_front();
                check("out_q", 32'(bus.out_q), 32'(r.q));
`ifdef MUX_GATE_EDGE_EN
                check("edge_p", 32'(bus.edge_p), 32'(r.e));
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: summary not reached within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        bus.in  = '0;
        bus.sel = '0;

        // Held in reset: clocked outputs stay 0 while out tracks sel.
        for (int s = 0; s < N; s++) step(4'b1011, SEL_W'(s), 1'b1);

        // Released: walk every select code.
        for (int s = 0; s < N; s++) step(4'b1011, SEL_W'(s), 1'b0);

        // Unselected inputs toggle with sel=2, then the selected one.
        step(4'b1011, 2'b10, 1'b0);
        step(4'b1010, 2'b10, 1'b0);
        step(4'b1000, 2'b10, 1'b0);
        step(4'b0000, 2'b10, 1'b0);
        step(4'b0100, 2'b10, 1'b0);
        step(4'b0000, 2'b10, 1'b0);

        // Falling out_q on sel 01->10, then steady select.
        step(4'b1011, 2'b01, 1'b0);
        step(4'b1011, 2'b01, 1'b0);
        step(4'b1011, 2'b10, 1'b0);
        step(4'b1011, 2'b10, 1'b0);
        step(4'b1011, 2'b10, 1'b0);

        // Asynchronous reset between edges while out_q is high.
        step(4'b1011, 2'b00, 1'b0);
        @(posedge clk);
        #3;
        check("out_q_before_rst", 32'(bus.out_q), 32'd1);
        rst = 1'b1;
        #1;
        check("out_q_async_rst", 32'(bus.out_q), 32'd0);
`ifdef MUX_GATE_EDGE_EN
        check("edge_p_async_rst", 32'(bus.edge_p), 32'd0);
`endif
        model_q = 1'b0;
        step(4'b1011, 2'b00, 1'b1);
        step(4'b1011, 2'b00, 1'b0);

        // Random traffic with occasional reset pulses.
        repeat (300) begin
            step(N'($urandom), SEL_W'($urandom), ($urandom_range(0, 15) == 0));
        end
        step(4'b0000, 2'b00, 1'b0);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(comb_q.size() + reg_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
